// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and iterative-unit mode selects for the
// multi-cycle ALU and the control decoder.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  // Mode select for the iterative mul/div unit
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide over N steps,
// sharing one 2N-bit {hi,lo} shift register.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] lo,
  output logic [N-1:0] hi,
  output logic         last
);

  logic [N-1:0]  hi_q, lo_q, b_q;
  logic [CW-1:0] cnt;
  logic          busy, div_q;
  logic [N:0]    add_s, sh, sub_s;
  logic          ge;

  // lo/hi present the value after this cycle's step, so the top can capture
  // the final result on the same edge as the last step.
  always_comb begin
    add_s = {1'b0, hi_q} + {1'b0, b_q};
    sh    = {hi_q, lo_q[N-1]};
    sub_s = sh - {1'b0, b_q};
    ge    = sh >= {1'b0, b_q};
    hi    = {1'b0, hi_q[N-1:1]};
    lo    = {hi_q[0], lo_q[N-1:1]};
    if (div_q == MODE_DIV) begin
      hi = ge ? sub_s[N-1:0] : sh[N-1:0];
      lo = {lo_q[N-2:0], ge};
    end else if (lo_q[0]) begin
      hi = add_s[N:1];
      lo = {add_s[0], lo_q[N-1:1]};
    end
  end

  assign last = busy && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      div_q <= MODE_MUL;
    end else if (start) begin
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
      cnt   <= CW'(N - 1);
      busy  <= 1'b1;
      div_q <= mode;
    end else if (busy) begin
      hi_q <= hi;
      lo_q <= lo;
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops plus iterative
// MUL/DIVU/REMU, valid/ready on both sides, flags registered with the result.
module seq_alu
  import alu_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res_lo,
  output logic [N-1:0] res_hi,
  output logic         zero,
  output logic         carry,
  output logic         ovf,
  output logic         dbz
);

  state_e       state;
  logic [3:0]   op_q;
  logic         dbz_q;
  logic         md_start, md_last;
  logic [N-1:0] md_lo, md_hi, it_lo, it_hi;
  logic [N:0]   add_s, sub_s;
  logic [N-1:0] sc_lo;
  logic         sc_known, sc_c, sc_v;

  assign md_start = (state == S_IDLE) && in_valid && is_iter(op);

  alu_iter_muldiv #(.N(N), .CW(CW)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .mode  ((op == OP_MUL) ? MODE_MUL : MODE_DIV),
    .a     (a),
    .b     (b),
    .lo    (md_lo),
    .hi    (md_hi),
    .last  (md_last)
  );

  // REMU reports the remainder in lo, so the halves swap
  assign it_lo = (op_q == OP_REMU) ? md_hi : md_lo;
  assign it_hi = (op_q == OP_REMU) ? md_lo : md_hi;

  always_comb begin
    add_s    = {1'b0, a} + {1'b0, b};
    sub_s    = {1'b0, a} - {1'b0, b};
    sc_lo    = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_known = 1'b1;
    case (op)
      OP_AND:  sc_lo = a & b;
      OP_OR:   sc_lo = a | b;
      OP_ADD: begin
        sc_lo = add_s[N-1:0];
        sc_c  = add_s[N];
        sc_v  = (a[N-1] == b[N-1]) && (add_s[N-1] != a[N-1]);
      end
      OP_SUB: begin
        sc_lo = sub_s[N-1:0];
        sc_c  = ~sub_s[N];
        sc_v  = (a[N-1] != b[N-1]) && (sub_s[N-1] != a[N-1]);
      end
      OP_SLTU: sc_lo = N'(a < b);
      OP_SLT:  sc_lo = N'($signed(a) < $signed(b));
      default: sc_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res_lo    <= '0;
      res_hi    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
      op_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          if (is_iter(op)) begin
            op_q  <= op;
            dbz_q <= (op != OP_MUL) && (b == '0);
            state <= S_RUN;
          end else begin
            res_lo    <= sc_lo;
            res_hi    <= '0;
            zero      <= sc_known && (sc_lo == '0);
            carry     <= sc_c;
            ovf       <= sc_v;
            dbz       <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_RUN: if (md_last) begin
          res_lo    <= it_lo;
          res_hi    <= it_hi;
          zero      <= (it_lo == '0);
          carry     <= 1'b0;
          ovf       <= 1'b0;
          dbz       <= dbz_q;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (N=32): expected results come from a behavioural
// reference model and are compared when the DUT raises out_valid.
module tb_seq_alu;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] a, b, res_lo, res_hi;
  logic        zero, carry, ovf, dbz;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z, c, v, d;
    int          lat;
  } exp_t;

  exp_t sb[$];

  seq_alu #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res_lo(res_lo), .res_hi(res_hi), .zero(zero), .carry(carry),
    .ovf(ovf), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [32:0] s;
    logic [63:0] p;
    e.lo = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.d = 1'b0; e.lat = 1;
    case (o)
      4'b0000: e.lo = x & y;
      4'b0001: e.lo = x | y;
      4'b0010: begin
        s = {1'b0, x} + {1'b0, y};
        e.lo = s[31:0]; e.c = s[32];
        e.v = (x[31] == y[31]) && (e.lo[31] != x[31]);
      end
      4'b0100: begin
        e.lo = x - y; e.c = (x >= y);
        e.v = (x[31] != y[31]) && (e.lo[31] != x[31]);
      end
      4'b0101: begin
        p = {32'd0, x} * {32'd0, y};
        e.lo = p[31:0]; e.hi = p[63:32]; e.lat = 33;
      end
      4'b0110: e.lo = (x < y) ? 32'd1 : 32'd0;
      4'b0111: e.lo = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1001, 4'b1010: begin
        e.lat = 33;
        if (y == 0) begin e.lo = 32'hFFFF_FFFF; e.hi = x; e.d = 1'b1; end
        else begin e.lo = x / y; e.hi = x % y; end
        if (o == 4'b1010) begin p = {e.lo, e.hi}; e.lo = p[31:0]; e.hi = p[63:32]; end
      end
      default: ;
    endcase
    e.z = (o inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                     4'b1001, 4'b1010}) && (e.lo == 0);
    return e;
  endfunction

  // Issue one op, wait for its result, compare against the scoreboard, then drain.
  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    exp_t e;
    int   lat, w;
    bit   rdy_hi;
    sb.push_back(model(o, x, y));
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; rdy_hi = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_hi = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    checks++;
    if (!out_valid) begin
      failures++; $display("FAIL %s timeout: out_valid never rose within %0d cycles", name, lat);
    end
    checks++;
    if (lat !== e.lat) begin
      failures++; $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
    end
    checks++;
    if (rdy_hi || in_ready !== 1'b0) begin
      failures++; $display("FAIL %s in_ready: high while busy (got %b expected 0)", name, in_ready);
    end
    checks++;
    if (res_lo !== e.lo || res_hi !== e.hi) begin
      failures++;
      $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h", name, res_hi, res_lo, e.hi, e.lo);
    end
    checks++;
    if ({zero, carry, ovf, dbz} !== {e.z, e.c, e.v, e.d}) begin
      failures++;
      $display("FAIL %s flags zcvd: got %b%b%b%b expected %b%b%b%b", name, zero, carry, ovf, dbz,
               e.z, e.c, e.v, e.d);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready, res_lo, res_hi, zero, carry, ovf, dbz} !== {1'b0, 1'b1, 64'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_state: got ov=%b ir=%b lo=%h hi=%h zcvd=%b%b%b%b expected ov=0 ir=1 all 0",
               out_valid, in_ready, res_lo, res_hi, zero, carry, ovf, dbz);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_single;
    run_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'd1);
    run_op("add_carry", 4'b0010, 32'hFFFF_FFFF, 32'd1);
    run_op("sub_eq",   4'b0100, 32'h1234, 32'h1234);
    run_op("sub_borrow", 4'b0100, 32'd1, 32'd2);
    run_op("slt",      4'b0111, 32'hFFFF_FFFF, 32'd1);
    run_op("sltu",     4'b0110, 32'hFFFF_FFFF, 32'd1);
    run_op("and",      4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF);
    run_op("or",       4'b0001, 32'hA000_0001, 32'h0500_0010);
    run_op("undef_op", 4'b1111, 32'h1234_5678, 32'h0000_0001);
  endtask

  task automatic test_muldiv;
    run_op("mul_max",  4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_zero", 4'b0101, 32'd0, 32'h1234_5678);
    run_op("divu",     4'b1001, 32'd100, 32'd7);
    run_op("remu",     4'b1010, 32'd100, 32'd7);
    run_op("divu_big", 4'b1001, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("divu_dbz", 4'b1001, 32'd5, 32'd0);
  endtask

  task automatic test_random;
    logic [3:0] ops [9];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010};
    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      x = $urandom; y = (i % 6 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op("random", ops[$urandom_range(0, 8)], x, y);
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    int   w;
    sb.push_back(model(4'b0010, 32'd10, 32'd20));
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    op = 4'b0010; a = 32'd10; b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 4'b0001; a = 32'd5; b = 32'd6;
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || res_lo !== e.lo || res_hi !== e.hi ||
          {zero, carry, ovf, dbz} !== {e.z, e.c, e.v, e.d}) begin
        failures++;
        $display("FAIL stall_hold cycle %0d: got ov=%b ir=%b lo=%h expected ov=1 ir=0 lo=%h",
                 i, out_valid, in_ready, res_lo, e.lo);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL stall_release: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL stall_no_accept: got ov=%b lo=%h expected ov=0", out_valid, res_lo);
    end
  endtask

  task automatic test_reset_mid_run;
    op = 4'b0101; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, res_lo, res_hi, zero, carry, ovf, dbz} !== {1'b0, 1'b1, 64'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_mid_run: got ov=%b ir=%b lo=%h hi=%h dbz=%b expected ov=0 ir=1 all 0",
               out_valid, in_ready, res_lo, res_hi, dbz);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid_idle: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready);
    end
    run_op("add_after_reset", 4'b0010, 32'd2, 32'd3);
  endtask

  initial begin
    test_reset;
    test_single;
    test_muldiv;
    test_random;
    test_backpressure;
    run_op("divu_dbz_again", 4'b1001, 32'd5, 32'd0);
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
